// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB slave port between NUM_REQ requesters.
// Winner's request is latched, run as SETUP/ACCESS, and answered with a one-cycle response pulse.
//
//   state  | meaning
//   IDLE   | bus idle, arbitrate among pending requests
//   SETUP  | APB setup phase (sel=1, enable=0), one cycle
//   ACCESS | APB access phase, wait for ready or watchdog abort
module apb_master_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_err,
  output logic                          apb_sel,
  output logic                          apb_enable,
  output logic                          apb_write,
  output logic [ADDR_WIDTH-1:0]         apb_addr,
  output logic [DATA_WIDTH-1:0]         apb_wdata,
  input  logic [DATA_WIDTH-1:0]         apb_rdata,
  input  logic                          apb_ready,
  input  logic                          apb_slv_err
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t                state, state_n;
  logic [IW-1:0]         rr, rr_n;
  logic [IW-1:0]         owner, owner_n;
  logic [CW-1:0]         cnt, cnt_n;
  logic [NUM_REQ-1:0]    req_ready_n, rsp_valid_n;
  logic [DATA_WIDTH-1:0] rsp_rdata_n, apb_wdata_n;
  logic [ADDR_WIDTH-1:0] apb_addr_n;
  logic                  rsp_err_n, apb_sel_n, apb_enable_n, apb_write_n;

  logic                  found;
  logic [IW-1:0]         win;

  // First pending requester after the last winner, wrapping modulo NUM_REQ.
  always_comb begin
    int cand;
    found = 1'b0;
    win   = '0;
    cand  = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = (int'(rr) + k) % NUM_REQ;
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = IW'(cand);
      end
    end
  end

  always_comb begin
    state_n      = state;
    rr_n         = rr;
    owner_n      = owner;
    cnt_n        = cnt;
    req_ready_n  = '0;
    rsp_valid_n  = '0;
    rsp_rdata_n  = '0;
    rsp_err_n    = 1'b0;
    apb_sel_n    = 1'b0;
    apb_enable_n = 1'b0;
    apb_write_n  = apb_write;
    apb_addr_n   = apb_addr;
    apb_wdata_n  = apb_wdata;

    unique case (state)
      IDLE: begin
        if (found) begin
          state_n          = SETUP;
          apb_sel_n        = 1'b1;
          req_ready_n[win] = 1'b1;
          rr_n             = win;
          owner_n          = win;
          apb_write_n      = req_write[win];
          apb_addr_n       = req_addr[int'(win)*ADDR_WIDTH +: ADDR_WIDTH];
          apb_wdata_n      = req_wdata[int'(win)*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      SETUP: begin
        state_n      = ACCESS;
        apb_sel_n    = 1'b1;
        apb_enable_n = 1'b1;
        cnt_n        = '0;
      end
      ACCESS: begin
        apb_sel_n    = 1'b1;
        apb_enable_n = 1'b1;
        if (apb_ready) begin
          state_n            = IDLE;
          apb_sel_n          = 1'b0;
          apb_enable_n       = 1'b0;
          rsp_valid_n[owner] = 1'b1;
          rsp_err_n          = apb_slv_err;
          rsp_rdata_n        = apb_write ? '0 : apb_rdata;
        end else if (cnt == CNT_LAST) begin
          // Watchdog abort: slave never answered within TIMEOUT access cycles.
          state_n            = IDLE;
          apb_sel_n          = 1'b0;
          apb_enable_n       = 1'b0;
          rsp_valid_n[owner] = 1'b1;
          rsp_err_n          = 1'b1;
        end else if (cnt != CNT_MAX) begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      rr         <= IW'(NUM_REQ - 1);
      owner      <= '0;
      cnt        <= '0;
      req_ready  <= '0;
      rsp_valid  <= '0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      apb_sel    <= 1'b0;
      apb_enable <= 1'b0;
      apb_write  <= 1'b0;
      apb_addr   <= '0;
      apb_wdata  <= '0;
    end else begin
      state      <= state_n;
      rr         <= rr_n;
      owner      <= owner_n;
      cnt        <= cnt_n;
      req_ready  <= req_ready_n;
      rsp_valid  <= rsp_valid_n;
      rsp_rdata  <= rsp_rdata_n;
      rsp_err    <= rsp_err_n;
      apb_sel    <= apb_sel_n;
      apb_enable <= apb_enable_n;
      apb_write  <= apb_write_n;
      apb_addr   <= apb_addr_n;
      apb_wdata  <= apb_wdata_n;
    end
  end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Directed bench for apb_master_arbiter with a small behavioural APB slave.
module tb_apb_master_arbiter;

  localparam int NR = 4;
  localparam int AW = 8;
  localparam int DW = 32;
  localparam int TO = 16;

  logic            clk;
  logic            reset;
  logic [NR-1:0]   req_valid;
  logic [NR-1:0]   req_write;
  logic [NR*AW-1:0] req_addr;
  logic [NR*DW-1:0] req_wdata;
  logic [NR-1:0]   req_ready;
  logic [NR-1:0]   rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            rsp_err;
  logic            apb_sel, apb_enable, apb_write;
  logic [AW-1:0]   apb_addr;
  logic [DW-1:0]   apb_wdata;
  logic [DW-1:0]   apb_rdata;
  logic            apb_ready;
  logic            apb_slv_err;

  // slave mode: 0 = ready at once, 1 = never ready, 2 = ready with error
  int              slv_mode;
  logic [DW-1:0]   mem [256];

  int n_chk  = 0;
  int n_pass = 0;

  apb_master_arbiter #(.NUM_REQ(NR), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .apb_sel(apb_sel), .apb_enable(apb_enable), .apb_write(apb_write),
    .apb_addr(apb_addr), .apb_wdata(apb_wdata), .apb_rdata(apb_rdata),
    .apb_ready(apb_ready), .apb_slv_err(apb_slv_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign apb_ready   = apb_sel && apb_enable && (slv_mode != 1);
  assign apb_slv_err = (slv_mode == 2);
  assign apb_rdata   = mem[apb_addr];

  always @(posedge clk)
    if (apb_sel && apb_enable && apb_ready && apb_write) mem[apb_addr] <= apb_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  task automatic set_req(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid[idx] = 1'b1;
    req_write[idx] = wr;
    req_addr[idx*AW +: AW] = a;
    req_wdata[idx*DW +: DW] = d;
  endtask

  // One transfer from requester idx; reports what was seen at grant and at response.
  task automatic xfer(input int idx, input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      output logic [NR-1:0] gnt, output logic setup_en, output logic [AW-1:0] setup_addr,
                      output logic [NR-1:0] rsp, output logic [DW-1:0] rd, output logic err,
                      output int acc, output logic wr_bad, output logic sel_at_rsp);
    int i;
    @(negedge clk);
    set_req(idx, wr, a, d);
    for (i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready != '0) break;
    end
    gnt = req_ready;
    setup_en = apb_enable;
    setup_addr = apb_addr;
    wr_bad = (apb_write !== wr);
    req_valid[idx] = 1'b0;
    acc = 0;
    for (i = 0; i < 100; i++) begin
      @(negedge clk);
      if (apb_sel && apb_enable) acc++;
      if (apb_sel && (apb_write !== wr)) wr_bad = 1'b1;
      if (rsp_valid != '0) break;
    end
    rsp = rsp_valid;
    rd = rsp_rdata;
    err = rsp_err;
    sel_at_rsp = apb_sel | apb_enable;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  logic [NR-1:0] gnt, rsp;
  logic [DW-1:0] rd;
  logic [AW-1:0] sa;
  logic          se, err, wb, sr;
  int            acc;
  int            gq[$];
  int            rq[$];

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 32'hA500_0000 | i;
    slv_mode  = 0;
    reset     = 1'b1;
    req_valid = '0;
    req_write = '0;
    req_addr  = '0;
    req_wdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {apb_sel, apb_enable, apb_write, rsp_err, req_ready, rsp_valid}, 0);
    chk("rst_data", apb_addr | apb_wdata | rsp_rdata, 0);
    reset = 1'b0;

    // 1: req0 write
    xfer(0, 1'b1, 8'h10, 32'hDEADBEEF, gnt, se, sa, rsp, rd, err, acc, wb, sr);
    chk("t1_grant", gnt, 4'b0001);
    chk("t1_setup_en", se, 0);
    chk("t1_setup_addr", sa, 8'h10);
    chk("t1_rsp", rsp, 4'b0001);
    chk("t1_err", err, 0);
    chk("t1_rdata", rd, 0);
    chk("t1_access", acc, 1);
    chk("t1_bus_idle", sr, 0);
    @(negedge clk);
    chk("t1_rsp_pulse", rsp_valid, 0);

    // 2: req2 read back
    xfer(2, 1'b0, 8'h10, 32'h0, gnt, se, sa, rsp, rd, err, acc, wb, sr);
    chk("t2_grant", gnt, 4'b0100);
    chk("t2_rsp", rsp, 4'b0100);
    chk("t2_rdata", rd, 32'hDEADBEEF);
    chk("t2_write_low", wb, 0);
    chk("t2_err", err, 0);

    // 3: all requesting continuously from reset
    do_reset();
    @(negedge clk);
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, AW'(8'h20 + i), 32'h0);
    for (int c = 0; c < 200 && gq.size() < 5; c++) begin
      @(negedge clk);
      for (int i = 0; i < NR; i++) begin
        if (req_ready[i]) gq.push_back(i);
        if (rsp_valid[i]) rq.push_back(i);
      end
    end
    req_valid = '0;
    chk("t3_ngrants", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk($sformatf("t3_grant%0d", i), gq[i], i % NR);
    chk("t3_nrsp", rq.size(), 4);
    for (int i = 0; i < rq.size(); i++) chk($sformatf("t3_rsp%0d", i), rq[i], i);
    repeat (5) @(negedge clk);

    // 4: watchdog abort
    slv_mode = 1;
    xfer(1, 1'b0, 8'h10, 32'h0, gnt, se, sa, rsp, rd, err, acc, wb, sr);
    chk("t4_access_cycles", acc, TO);
    chk("t4_rsp", rsp, 4'b0010);
    chk("t4_err", err, 1);
    chk("t4_rdata", rd, 0);
    chk("t4_bus_idle", sr, 0);

    // 5: slave error then clean transfer
    slv_mode = 2;
    xfer(3, 1'b0, 8'h05, 32'h0, gnt, se, sa, rsp, rd, err, acc, wb, sr);
    chk("t5_rsp", rsp, 4'b1000);
    chk("t5_err", err, 1);
    slv_mode = 0;
    xfer(0, 1'b1, 8'h30, 32'h12345678, gnt, se, sa, rsp, rd, err, acc, wb, sr);
    chk("t5_next_rsp", rsp, 4'b0001);
    chk("t5_next_err", err, 0);
    chk("t5_mem", mem[8'h30], 32'h12345678);

    // 6: reset during ACCESS
    slv_mode = 1;
    @(negedge clk);
    set_req(2, 1'b1, 8'h44, 32'hCAFEF00D);
    for (int c = 0; c < 20 && !(apb_sel && apb_enable); c++) @(negedge clk);
    chk("t6_in_access", apb_sel & apb_enable, 1);
    req_valid = '0;
    reset = 1'b1;
    @(negedge clk);
    chk("t6_rst_outputs", {apb_sel, apb_enable, apb_write, rsp_err, req_ready, rsp_valid}, 0);
    chk("t6_rst_data", apb_addr | apb_wdata | rsp_rdata, 0);
    slv_mode = 0;
    set_req(1, 1'b0, 8'h10, 32'h0);
    set_req(0, 1'b0, 8'h30, 32'h0);
    @(negedge clk);
    chk("t6_no_rsp", rsp_valid, 0);
    reset = 1'b0;
    gnt = '0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (req_ready != '0) begin
        gnt = req_ready;
        break;
      end
    end
    req_valid = '0;
    chk("t6_first_grant", gnt, 4'b0001);
    repeat (10) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
